// File: rtl/up_882_if.sv
// up_882_if: stereo sample bus between an 88.2K source and the up_882 interpolator
// master drives x0/x1 and receives pcm_*; slave is the interpolator side
interface up_882_if;
  logic signed [31:0] x0, x1, pcm_left, pcm_right;
  logic               pcm_stb, pcm_phase;
  modport master (output x0, x1, input pcm_left, pcm_right, pcm_stb, pcm_phase);
  modport slave  (input x0, x1, output pcm_left, pcm_right, pcm_stb, pcm_phase);
endinterface

// File: rtl/up_882.sv
// up_882: 2x half-band polyphase interpolator, 88.2K stereo in -> 176.4K stereo out, 32-bit samples
// ports: bck176 bit clock, reset_n async active-low reset, bus (slave) carries x0/x1 in and pcm_left/pcm_right/pcm_stb/pcm_phase out
// UP882_SATURATE_EN: when defined, pcm clamps on 32-bit overflow instead of wrapping
module up_882 #(
  parameter int NTAP      = 47,
  parameter int NHIST     = 24,
  parameter int SAMPLE_AT = 2
) (
  input logic     bck176,
  input logic     reset_n,
  up_882_if.slave bus
);
  localparam logic [5:0] LAST0 = 6'((NTAP - 1) / 2);
  localparam logic [5:0] LAST1 = 6'(NHIST - 2);
  logic [6:0]              cnt_q, cnt_d;
  logic [NHIST-1:0][27:0]  hist_l_q, hist_l_d, hist_r_q, hist_r_d;
  logic [27:0]             stage_l_q, stage_l_d, stage_r_q, stage_r_d;
  logic signed [59:0]      sum_l_q, sum_l_d, sum_r_q, sum_r_d, prod_l, prod_r;
  logic [31:0]             pcm_left_q, pcm_left_d, pcm_right_q, pcm_right_d;
  logic                    pcm_stb_q, pcm_stb_d, pcm_phase_q, pcm_phase_d;
  logic                    mac, dump, ovf_l, ovf_r;
  logic [4:0]              j;
  logic signed [31:0]      tap;
  logic                    unused_ok;
  // Half-band prototype: even taps carry the interpolated phase, odd taps are zero except the centre.
  always_comb
    case ({j, cnt_q[6]})
      6'd0,  6'd46: tap = -32'sd254000;
      6'd2,  6'd44: tap =  32'sd2478000;
      6'd4,  6'd42: tap = -32'sd7430000;
      6'd6,  6'd40: tap =  32'sd15720000;
      6'd8,  6'd38: tap = -32'sd28132000;
      6'd10, 6'd36: tap =  32'sd45741000;
      6'd12, 6'd34: tap = -32'sd70266000;
      6'd14, 6'd32: tap =  32'sd105012000;
      6'd16, 6'd30: tap = -32'sd157110000;
      6'd18, 6'd28: tap =  32'sd245157000;
      6'd20, 6'd26: tap = -32'sd438344000;
      6'd22, 6'd24: tap =  32'sd1361169824;
      6'd23:        tap =  32'sh7FFFFFFF;
      default:      tap = '0;
    endcase
  always_comb begin
    mac = cnt_q[5:0] <= (cnt_q[6] ? LAST1 : LAST0);
    j = mac ? cnt_q[4:0] : '0;
    dump = &cnt_q[5:0];
    prod_l = 60'($signed(hist_l_q[j])) * 60'(tap);
    prod_r = 60'($signed(hist_r_q[j])) * 60'(tap);
`ifdef UP882_SATURATE_EN
    ovf_l = sum_l_q[59] ^ sum_l_q[58];
    ovf_r = sum_r_q[59] ^ sum_r_q[58];
`else
    ovf_l = 1'b0;
    ovf_r = 1'b0;
`endif
    cnt_d = cnt_q + 7'd1;
    stage_l_d = cnt_q == 7'(SAMPLE_AT) ? bus.x0[31:4] : stage_l_q;
    stage_r_d = cnt_q == 7'(SAMPLE_AT) ? bus.x1[31:4] : stage_r_q;
    hist_l_d = dump && cnt_q[6] ? {hist_l_q[NHIST-2:0], stage_l_q} : hist_l_q;
    hist_r_d = dump && cnt_q[6] ? {hist_r_q[NHIST-2:0], stage_r_q} : hist_r_q;
    sum_l_d = dump ? '0 : mac ? sum_l_q + prod_l : sum_l_q;
    sum_r_d = dump ? '0 : mac ? sum_r_q + prod_r : sum_r_q;
    pcm_left_d = dump ? (ovf_l ? {sum_l_q[59], {31{~sum_l_q[59]}}} : sum_l_q[58:27]) : pcm_left_q;
    pcm_right_d = dump ? (ovf_r ? {sum_r_q[59], {31{~sum_r_q[59]}}} : sum_r_q[58:27]) : pcm_right_q;
    pcm_stb_d = dump;
    pcm_phase_d = dump ? cnt_q[6] : pcm_phase_q;
  end
  always_ff @(posedge bck176 or negedge reset_n)
    if (!reset_n) begin
      cnt_q       <= '0;
      hist_l_q    <= '0;
      hist_r_q    <= '0;
      stage_l_q   <= '0;
      stage_r_q   <= '0;
      sum_l_q     <= '0;
      sum_r_q     <= '0;
      pcm_left_q  <= '0;
      pcm_right_q <= '0;
      pcm_stb_q   <= 1'b0;
      pcm_phase_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hist_l_q    <= hist_l_d;
      hist_r_q    <= hist_r_d;
      stage_l_q   <= stage_l_d;
      stage_r_q   <= stage_r_d;
      sum_l_q     <= sum_l_d;
      sum_r_q     <= sum_r_d;
      pcm_left_q  <= pcm_left_d;
      pcm_right_q <= pcm_right_d;
      pcm_stb_q   <= pcm_stb_d;
      pcm_phase_q <= pcm_phase_d;
    end
  assign bus.pcm_left  = pcm_left_q;
  assign bus.pcm_right = pcm_right_q;
  assign bus.pcm_stb   = pcm_stb_q;
  assign bus.pcm_phase = pcm_phase_q;
  assign unused_ok = ^{bus.x0[3:0], bus.x1[3:0], sum_l_q[26:0], sum_r_q[26:0]};
endmodule
